phys_reg_free_list: RTL

- Manages the physical-register free list for the register renaming unit of the RV64 out-of-order core.
- Grants one free physical register per cycle to rename.
- Takes back one released physical register per cycle from ROB commit, i.e. the previous mapping of the committing destination.
- On pipeline flush, reclaims every register allocated after the last committed allocation by restoring a committed head pointer.

---
 rtl/phys_reg_free_list.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/phys_reg_free_list.sv
// Physical-register free list for the rename stage: a circular queue of free preg indices
// with a speculative head, a committed head for flush recovery, and a tail fed by ROB commit.
module phys_reg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
    parameter int PW        = $clog2(NUM_PREGS),
    parameter int CW        = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          alloc_req,
    output logic          alloc_ready,
    output logic [PW-1:0] alloc_preg,
    input  logic          commit_valid,
    input  logic          free_valid,
    input  logic [PW-1:0] free_preg,
    input  logic          flush,
    output logic [CW-1:0] free_count,
    output logic          init_done
);

    localparam int IW = CW - 1;
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [CW-1:0] INIT_LAST_C = CW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] head_r, commit_r, tail_r, init_cnt_r;
    logic [CW-1:0] head_nxt_s, commit_nxt_s, tail_nxt_s, init_cnt_nxt_s;
    logic [PW-1:0] mem_r [DEPTH];
    logic          wr_en_s;
    logic [IW-1:0] wr_idx_s;
    logic [PW-1:0] wr_data_s;
    logic          grant_s;

    // Output view of the list; a flushing cycle never grants.
    always_comb begin
        free_count  = tail_r - head_r;
        init_done   = (state_r == ST_READY);
        alloc_ready = (state_r == ST_READY) && (free_count != '0) && !flush;
        if (alloc_ready) begin
            alloc_preg = mem_r[head_r[IW-1:0]];
        end else begin
            alloc_preg = '0;
        end
        grant_s = alloc_req && alloc_ready;
    end

    // Next-state: INIT fills the list with NUM_AREGS.., READY serves alloc/free/commit/flush.
    always_comb begin
        state_nxt_s    = state_r;
        head_nxt_s     = head_r;
        commit_nxt_s   = commit_r;
        tail_nxt_s     = tail_r;
        init_cnt_nxt_s = init_cnt_r;
        wr_en_s        = 1'b0;
        wr_idx_s       = tail_r[IW-1:0];
        wr_data_s      = free_preg;
        case (state_r)
            ST_INIT: begin
                wr_en_s        = 1'b1;
                wr_data_s      = PW'(NUM_AREGS) + PW'(init_cnt_r);
                tail_nxt_s     = tail_r + ONE_C;
                init_cnt_nxt_s = init_cnt_r + ONE_C;
                if (init_cnt_r == INIT_LAST_C) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_READY: begin
                // The commit in the flush cycle is older than the flush, so it survives.
                commit_nxt_s = commit_r + (commit_valid ? ONE_C : '0);
                if (flush) begin
                    head_nxt_s = commit_nxt_s;
                end else if (grant_s) begin
                    head_nxt_s = head_r + ONE_C;
                end else begin
                    head_nxt_s = head_r;
                end
                if (free_valid) begin
                    wr_en_s    = 1'b1;
                    tail_nxt_s = tail_r + ONE_C;
                end else begin
                    wr_en_s    = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r    <= ST_INIT;
            head_r     <= '0;
            commit_r   <= '0;
            tail_r     <= '0;
            init_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            head_r     <= head_nxt_s;
            commit_r   <= commit_nxt_s;
            tail_r     <= tail_nxt_s;
            init_cnt_r <= init_cnt_nxt_s;
        end
    end

    // List storage; contents are rebuilt by INIT after every reset.
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

    phys_reg_free_list_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
        .clk          (CLK),
        .rst_n        (RSTn),
        .in_init      (state_r == ST_INIT),
        .free_valid   (free_valid),
        .commit_valid (commit_valid),
        .free_count   (free_count),
        .head_ptr     (head_r),
        .commit_ptr   (commit_r)
    );

endmodule

// Protocol checker for the free list: illegal frees, overflow, commits past the head.
module phys_reg_free_list_chk #(
    parameter int CW    = 6,
    parameter int DEPTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    input logic          in_init,
    input logic          free_valid,
    input logic          commit_valid,
    input logic [CW-1:0] free_count,
    input logic [CW-1:0] head_ptr,
    input logic [CW-1:0] commit_ptr
);

    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    a_no_free_in_init: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_init && free_valid));

    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, free_count} <= DEPTH_C));

    a_commit_behind_head: assert property (@(posedge clk) disable iff (!rst_n)
        !(!in_init && commit_valid && (commit_ptr == head_ptr)));

endmodule
